sram_2168_ctrl: RTL and testbench

//  Synchronous request/ack front end for a bank of 2168 4Kx4 static RAMs (map/scratch storage).
//  - Turns single-clock read/write requests into correctly sequenced asynchronous SRAM cycles
//    on A[11:0], CE_n, WE_n and the bidirectional data pins.
//  - Sits directly upstream of the SRAM chips. Consumers are the MMU/bus logic.
//  - The data bus is split into dout/oe/din; the top level builds the tristate.

---
 rtl/sram_2168_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_2168_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sram_2168_ctrl.sv
// Request/ack front end for a bank of 2168 4Kx4 SRAMs: sequences registered A/CE_n/WE_n/D cycles.
// Define SRAM_CLEAR_EN to zero-fill the whole bank after every reset (busy high during the sweep).
module sram_2168_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int SETUP_CYC = 1,
  parameter int WE_CYC    = 2,
  parameter int RD_CYC    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_din
);

`ifdef SRAM_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  localparam int MAX_SW  = (SETUP_CYC > WE_CYC) ? SETUP_CYC : WE_CYC;
  localparam int MAX_CYC = (MAX_SW > RD_CYC) ? MAX_SW : RD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {IDLE, WSETUP, WPULSE, WHOLD, READ, ACK} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_ack, w_ack_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_clr_pend, w_clr_pend_nxt;
  logic [ADDR_W-1:0]   r_sram_a, w_a_nxt;
  logic                r_ce_n, w_ce_n_nxt;
  logic                r_we_n, w_we_n_nxt;
  logic                r_oe, w_oe_nxt;
  logic [DATA_W-1:0]   r_dout, w_dout_nxt;

  // Pins are registered from the next state, so each state's pin values appear in that state's cycle.
  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ack_nxt      = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_busy_nxt     = r_busy;
    w_clr_pend_nxt = r_clr_pend;
    w_a_nxt        = r_sram_a;
    w_ce_n_nxt     = r_ce_n;
    w_we_n_nxt     = r_we_n;
    w_oe_nxt       = r_oe;
    w_dout_nxt     = r_dout;

    case (r_state)
      IDLE: begin
        if (r_clr_pend) begin
          w_clr_pend_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = WSETUP;
          w_cnt_nxt      = CNT_W'(SETUP_CYC - 1);
          w_a_nxt        = '0;
          w_ce_n_nxt     = 1'b0;
          w_we_n_nxt     = 1'b1;
          w_oe_nxt       = 1'b1;
          w_dout_nxt     = '0;
        end else if (req && !r_busy) begin
          w_a_nxt    = addr;
          w_ce_n_nxt = 1'b0;
          w_we_n_nxt = 1'b1;
          if (we) begin
            w_state_nxt = WSETUP;
            w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
            w_oe_nxt    = 1'b1;
            w_dout_nxt  = wdata;
          end else begin
            w_state_nxt = READ;
            w_cnt_nxt   = CNT_W'(RD_CYC - 1);
            w_oe_nxt    = 1'b0;
          end
        end
      end

      WSETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = WPULSE;
          w_cnt_nxt   = CNT_W'(WE_CYC - 1);
          w_we_n_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      WPULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = WHOLD;
          w_we_n_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      WHOLD: begin
        w_state_nxt = ACK;
        w_ce_n_nxt  = 1'b1;
        w_oe_nxt    = 1'b0;
        w_ack_nxt   = !r_busy;
      end

      READ: begin
        if (r_cnt == '0) begin
          w_state_nxt = ACK;
          w_ce_n_nxt  = 1'b1;
          w_rdata_nxt = sram_din;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ACK: begin
        w_state_nxt = IDLE;
        // A sweep chains straight into the next word so each clear write costs exactly one write slot.
        if (r_busy) begin
          if (&r_sram_a) begin
            w_busy_nxt = 1'b0;
          end else begin
            w_state_nxt = WSETUP;
            w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
            w_a_nxt     = r_sram_a + ADDR_W'(1);
            w_ce_n_nxt  = 1'b0;
            w_oe_nxt    = 1'b1;
            w_dout_nxt  = '0;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_clr_pend <= CLEAR_EN;
      r_sram_a   <= '0;
      r_ce_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_oe       <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack      <= w_ack_nxt;
      r_rdata    <= w_rdata_nxt;
      r_busy     <= w_busy_nxt;
      r_clr_pend <= w_clr_pend_nxt;
      r_sram_a   <= w_a_nxt;
      r_ce_n     <= w_ce_n_nxt;
      r_we_n     <= w_we_n_nxt;
      r_oe       <= w_oe_nxt;
      r_dout     <= w_dout_nxt;
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign sram_a    = r_sram_a;
  assign sram_ce_n = r_ce_n;
  assign sram_we_n = r_we_n;
  assign sram_dout = r_dout;
  assign sram_oe   = r_oe;

endmodule

// File: tb/tb_sram_2168_ctrl.sv
// Directed bench for sram_2168_ctrl with a behavioural 4Kx8 SRAM model and a pin-protocol monitor.
// Build with SRAM_CLEAR_EN defined to also exercise the power-up clear sweep.
module tb_sram_2168_ctrl;
  localparam int DW = 8;
  localparam int AW = 12;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          req   = 1'b0;
  logic          we    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] sram_a;
  logic          sram_ce_n;
  logic          sram_we_n;
  logic [DW-1:0] sram_dout;
  logic          sram_oe;
  logic [DW-1:0] sram_din;

  sram_2168_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .SETUP_CYC(1), .WE_CYC(2), .RD_CYC(2)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy),
    .sram_a(sram_a), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
    .sram_dout(sram_dout), .sram_oe(sram_oe), .sram_din(sram_din)
  );

  always #5 clk = ~clk;

  // SRAM model: stores while CE_n and WE_n are low with the bus driven, reads when enabled and undriven.
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_oe) mem[sram_a] <= sram_dout;
  assign sram_din = (!sram_ce_n && sram_we_n && !sram_oe) ? mem[sram_a] : 'x;

  int n_tests   = 0;
  int n_fail    = 0;
  int proto_err = 0;
  bit in_read   = 1'b0;

  logic [AW-1:0] p_a    = '0;
  logic [DW-1:0] p_dout = '0;
  logic          p_we_n = 1'b1;

  always @(negedge clk) begin
    if (!reset) begin
      if (!sram_we_n && !p_we_n && (sram_a !== p_a || sram_dout !== p_dout)) proto_err++;
      if (!sram_we_n && !(sram_ce_n === 1'b0 && sram_oe === 1'b1)) proto_err++;
      if (in_read && sram_oe !== 1'b0) proto_err++;
    end
    p_a    = sram_a;
    p_dout = sram_dout;
    p_we_n = reset ? 1'b1 : sram_we_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency is counted from the first rising edge after the request is presented to the ack cycle.
  task automatic do_op(input string tag, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit hold, input int exp_lat,
                       input logic [DW-1:0] exp_rd);
    int lat;
    int we_low;
    lat    = -1;
    we_low = 0;
    req = 1'b1; we = w; addr = a; wdata = d; in_read = !w;
    @(posedge clk);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (!sram_we_n) we_low++;
      if (ack) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    if (w) check({tag, "_we_low"}, we_low, 2);
    else   check({tag, "_rdata"}, rdata, exp_rd);
    in_read = 1'b0;
    if (!hold) begin
      req = 1'b0;
      @(negedge clk);
      check({tag, "_single_ack"}, ack, 1'b0);
    end
  endtask

  task automatic wait_sweep(input string tag, input bit poke);
    int cyc;
    int acks;
    cyc  = 0;
    acks = 0;
    for (int k = 0; k < 25000; k++) begin
      @(negedge clk);
      if (poke && k < 100) begin
        req = 1'b1; we = 1'b0; addr = 12'h7FF;
      end else begin
        req = 1'b0;
      end
      if (ack) acks++;
      if (!busy) break;
      cyc++;
    end
    check({tag, "_busy_cycles"}, cyc, 20480);
    check({tag, "_no_ack"}, acks, 0);
  endtask

  initial begin
`ifdef SRAM_CLEAR_EN
    mem[12'h7FF] = 8'hFF;
`endif
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_a", sram_a, 12'h000);
    check("rst_ce_n", sram_ce_n, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe", sram_oe, 1'b0);
    check("rst_dout", sram_dout, 8'h00);
    reset = 1'b0;

`ifdef SRAM_CLEAR_EN
    wait_sweep("sweep", 1'b1);
    do_op("clr_rd_7ff", 1'b0, 12'h7FF, 8'h00, 1'b0, 3, 8'h00);
`endif

    do_op("t1_wr_123", 1'b1, 12'h123, 8'hA5, 1'b0, 5, 8'h00);
    do_op("t1_rd_123", 1'b0, 12'h123, 8'h00, 1'b0, 3, 8'hA5);

    // Back-to-back with req held: the ACK->IDLE edge adds one cycle before each acceptance.
    do_op("t3_wr_001", 1'b1, 12'h001, 8'h11, 1'b1, 5, 8'h00);
    do_op("t3_wr_002", 1'b1, 12'h002, 8'h22, 1'b1, 6, 8'h00);
    do_op("t3_rd_001", 1'b0, 12'h001, 8'h00, 1'b0, 4, 8'h11);

    req = 1'b1; we = 1'b1; addr = 12'h040; wdata = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t4_in_wpulse", sram_we_n, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("t4_ce_n", sram_ce_n, 1'b1);
    check("t4_we_n", sram_we_n, 1'b1);
    check("t4_oe", sram_oe, 1'b0);
    check("t4_ack", ack, 1'b0);
    check("t4_rdata", rdata, 8'h00);
    reset = 1'b0;
    req   = 1'b0;
`ifdef SRAM_CLEAR_EN
    wait_sweep("sweep2", 1'b0);
`endif
    do_op("t4_wr_041", 1'b1, 12'h041, 8'h77, 1'b0, 5, 8'h00);
    do_op("t4_rd_041", 1'b0, 12'h041, 8'h00, 1'b0, 3, 8'h77);

    do_op("t5_wr_fff", 1'b1, 12'hFFF, 8'hC3, 1'b0, 5, 8'h00);
    do_op("t5_wr_000", 1'b1, 12'h000, 8'h3C, 1'b0, 5, 8'h00);
    do_op("t5_rd_fff", 1'b0, 12'hFFF, 8'h00, 1'b0, 3, 8'hC3);
    do_op("t5_rd_000", 1'b0, 12'h000, 8'h00, 1'b0, 3, 8'h3C);

    do_op("hold_wr_555", 1'b1, 12'h555, 8'h99, 1'b0, 5, 8'h00);
    check("rdata_held", rdata, 8'h3C);

    check("protocol", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
